// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op encoding and sequencer states.
package mips_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } muldiv_state_t;

    function automatic logic op_is_signed(muldiv_op_t op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic op_is_div(muldiv_op_t op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/flopu.sv
// Resettable flop with synchronous clear and load enable.
module flopu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, followed by a single sign-fix cycle that commits HI/LO.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_e;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mag_b_q;
    logic             is_div_q, neg_q_q, neg_r_q;
    logic             done_q;
    logic             accept, commit, hi_en, lo_en;
    logic [WIDTH-1:0] hi_d, lo_d;

    // Operand preparation.
    logic             sa, sb, div0;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_e  = muldiv_op_t'(op);
    assign sa    = op_is_signed(op_e) & srca[WIDTH-1];
    assign sb    = op_is_signed(op_e) & srcb[WIDTH-1];
    assign mag_a = sa ? (~srca) + WIDTH'(1) : srca;
    assign mag_b = sb ? (~srcb) + WIDTH'(1) : srcb;
    assign div0  = (srcb == '0);

    // One iteration step; divide by zero naturally yields all-ones quotient
    // and the dividend magnitude as remainder.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff, step_hi, step_lo;
    logic             div_ge;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
    assign step_hi   = is_div_q ? (div_ge ? div_diff : div_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign step_lo   = is_div_q ? {acc_lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Sign correction applied in the fix cycle.
    logic [W2-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q_q ? (~prod) + W2'(1) : prod;
    assign quo_fix  = neg_q_q ? (~acc_lo_q) + WIDTH'(1) : acc_lo_q;
    assign rem_fix  = neg_r_q ? (~acc_hi_q) + WIDTH'(1) : acc_hi_q;
    assign res_hi   = is_div_q ? rem_fix : prod_fix[W2-1:WIDTH];
    assign res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        accept = (state_q == StIdle) && start && !flush;
        commit = (state_q == StFix) && !flush;
        hi_en  = commit || ((state_q == StIdle) && hiwrite);
        lo_en  = commit || ((state_q == StIdle) && lowrite);
        hi_d   = commit ? res_hi : wdata;
        lo_d   = commit ? res_lo : wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_b_q  <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (accept) begin
            cnt_q    <= CNTW'(WIDTH - 1);
            acc_hi_q <= '0;
            acc_lo_q <= mag_a;
            mag_b_q  <= mag_b;
            is_div_q <= op_is_div(op_e);
            neg_q_q  <= (sa ^ sb) & ~(op_is_div(op_e) & div0);
            neg_r_q  <= sa;
        end else if (state_q == StRun) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q != '0) cnt_q <= cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
        end
    end

    assign done = done_q;

    flopu #(.WIDTH(WIDTH)) u_hi (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (hi_en),
        .d     (hi_d),
        .q     (hi)
    );

    flopu #(.WIDTH(WIDTH)) u_lo (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (lo_en),
        .d     (lo_d),
        .q     (lo)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush, hiwrite, lowrite;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]  exp_q;
    logic [W-1:0] last_hi = '0, last_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .flush   (flush),
        .hiwrite (hiwrite),
        .lowrite (lowrite),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        int     ia = int'(a);
        int     ib = int'(b);
        longint p;
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        case (o)
            2'b00: begin
                p = longint'(ia) * longint'(ib);
                return p;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_q = model(o, a, b);
    endtask

    // n0: edges already elapsed since the accepting edge.
    task automatic await_result(input string tag, input int n0);
        int n = n0;
        bit seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq({tag, ".latency"}, 64'(n), 64'd33);
        check_eq({tag, ".busy"}, {63'b0, busy}, 64'd0);
        check_eq({tag, ".hi"}, {32'b0, hi}, {32'b0, exp_q[63:32]});
        check_eq({tag, ".lo"}, {32'b0, lo}, {32'b0, exp_q[31:0]});
        last_hi = exp_q[63:32];
        last_lo = exp_q[31:0];
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        launch(o, a, b);
        await_result(tag, 0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check_eq({tag, ".no_done"}, 64'(cnt), 64'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
        if ($urandom_range(0, 2) == 0) return W'($urandom_range(0, 20));
        return W'($urandom);
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
        op = 2'b00; srca = '0; srcb = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.hi", {32'b0, hi}, 64'd0);
        check_eq("reset.lo", {32'b0, lo}, 64'd0);
        check_eq("reset.busy", {63'b0, busy}, 64'd0);
        check_eq("reset.done", {63'b0, done}, 64'd0);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max.model", exp_q, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
        check_eq("mult_neg.model", exp_q, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_neg.model", exp_q, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd7, 32'd0);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_ovf.model", exp_q, 64'h0000_0000_8000_0000);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        op = 2'b01; srca = 32'd3; srcb = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_eq("idle_flush.busy", {63'b0, busy}, 64'd0);

        // Flush at cycle 10 of a divide.
        launch(2'b10, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_eq("flush.busy_before", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush.busy_after", {63'b0, busy}, 64'd0);
        check_eq("flush.hi_kept", {32'b0, hi}, {32'b0, last_hi});
        check_eq("flush.lo_kept", {32'b0, lo}, {32'b0, last_lo});
        watch_no_done("flush", 40);

        // Second start while running is ignored.
        launch(2'b11, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b01; srca = 32'd5; srcb = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        await_result("restart_ignored", 5);

        // Reset at cycle 20 of a multiply.
        launch(2'b00, 32'h0001_2345, 32'hFFFF_8765);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("midreset.hi", {32'b0, hi}, 64'd0);
        check_eq("midreset.lo", {32'b0, lo}, 64'd0);
        check_eq("midreset.busy", {63'b0, busy}, 64'd0);
        watch_no_done("midreset", 40);

        // MTHI / MTLO in IDLE.
        @(negedge clk);
        hiwrite = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk);
        #1 hiwrite = 1'b0;
        @(negedge clk);
        check_eq("mthi.hi", {32'b0, hi}, 64'h1234_5678);
        check_eq("mthi.lo", {32'b0, lo}, 64'd0);
        lowrite = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 lowrite = 1'b0;
        @(negedge clk);
        check_eq("mtlo.lo", {32'b0, lo}, 64'hCAFE_F00D);
        check_eq("mtlo.hi", {32'b0, hi}, 64'h1234_5678);

        // MTHI/MTLO while busy are ignored.
        launch(2'b01, 32'd3, 32'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        hiwrite = 1'b1; lowrite = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 hiwrite = 1'b0; lowrite = 1'b0;
        @(negedge clk);
        check_eq("busy_mthi.hi", {32'b0, hi}, 64'h1234_5678);
        check_eq("busy_mtlo.lo", {32'b0, lo}, 64'hCAFE_F00D);
        await_result("busy_write", 3);

        // Write coinciding with an accepted start: applied now, overwritten later.
        @(negedge clk);
        op = 2'b10; srca = 32'hFFFF_FF9C; srcb = 32'd7; start = 1'b1;
        hiwrite = 1'b1; wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        #1 start = 1'b0; hiwrite = 1'b0;
        exp_q = model(2'b10, 32'hFFFF_FF9C, 32'd7);
        @(negedge clk);
        check_eq("start_mthi.hi", {32'b0, hi}, 64'h0BAD_CAFE);
        await_result("start_mthi", 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
